// File: rtl/cpu_debug_cmd_sync.sv
// Sysclk-domain command front end for the JTAG debug slave: synchronises the update
// strobes, queues {ir, sr} commands in a FIFO, and emits one-hot action strobes on pop.
// Optional: define DBG_CMD_TIMESTAMP_EN to add a timestamp per command (parameter TS_W, port cmd_ts).
module cpu_debug_cmd_sync #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int QDEPTH      = 2,
  parameter int ACT_BIT     = 34
`ifdef DBG_CMD_TIMESTAMP_EN
  , parameter int TS_W      = 16
`endif
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [IR_W-1:0]           ir_in,
  input  logic [SR_W-1:0]           sr,
  input  logic                      vs_uir,
  input  logic                      vs_udr,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [IR_W-1:0]           cmd_ir,
  output logic [SR_W-1:0]           cmd_data,
  output logic [SR_W-1:0]           jdo,
  output logic [(1<<IR_W)-1:0]      act_strobe,
  output logic [(1<<IR_W)-1:0]      noact_strobe,
  output logic                      overrun,
  input  logic                      overrun_clr,
  output logic [$clog2(QDEPTH):0]   level
`ifdef DBG_CMD_TIMESTAMP_EN
  , output logic [TS_W-1:0]         cmd_ts
`endif
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int LVL_W = $clog2(QDEPTH) + 1;

  typedef struct packed {
`ifdef DBG_CMD_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } entry_t;

  logic [SYNC_STAGES-1:0] r_uir_sync, r_udr_sync;
  logic                   r_uir_hist, r_udr_hist;
  logic [IR_W-1:0]        r_ir;
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  entry_t                 r_mem [QDEPTH];
`ifdef DBG_CMD_TIMESTAMP_EN
  logic [TS_W-1:0]        r_ts;
`endif

  logic   w_uir_evt, w_udr_evt, w_full, w_pop, w_push, w_drop;
  entry_t w_head, w_new;

  // A level held high yields a single event: last stage high while history is still low.
  assign w_uir_evt = r_uir_sync[SYNC_STAGES-1] & ~r_uir_hist;
  assign w_udr_evt = r_udr_sync[SYNC_STAGES-1] & ~r_udr_hist;

  assign cmd_valid = (level != '0);
  assign w_full    = (level == LVL_W'(QDEPTH));
  assign w_pop     = cmd_valid & cmd_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push    = w_udr_evt & (~w_full | w_pop);
  assign w_drop    = w_udr_evt & w_full & ~w_pop;

  always_comb begin
    w_new      = '0;
    w_new.ir   = w_uir_evt ? ir_in : r_ir;
    w_new.data = sr;
`ifdef DBG_CMD_TIMESTAMP_EN
    w_new.ts   = r_ts;
`endif
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign cmd_ir   = w_head.ir;
  assign cmd_data = w_head.data;
`ifdef DBG_CMD_TIMESTAMP_EN
  assign cmd_ts   = w_head.ts;
`endif

  // NOTE: FIFO storage has no reset; the level counter alone decides what is valid,
  // which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_new;
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_uir_sync   <= '0;
      r_udr_sync   <= '0;
      r_uir_hist   <= 1'b0;
      r_udr_hist   <= 1'b0;
      r_ir         <= '0;
      jdo          <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      level        <= '0;
      overrun      <= 1'b0;
      act_strobe   <= '0;
      noact_strobe <= '0;
`ifdef DBG_CMD_TIMESTAMP_EN
      r_ts         <= '0;
`endif
    end else begin
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_hist <= r_uir_sync[SYNC_STAGES-1];
      r_udr_hist <= r_udr_sync[SYNC_STAGES-1];
`ifdef DBG_CMD_TIMESTAMP_EN
      r_ts       <= r_ts + TS_W'(1);
`endif

      if (w_uir_evt) r_ir <= ir_in;
      if (w_udr_evt) jdo  <= sr;

      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(QDEPTH-1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(QDEPTH-1)) ? '0 : r_rd_ptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      if (w_drop)           overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;

      act_strobe   <= '0;
      noact_strobe <= '0;
      if (w_pop) begin
        if (w_head.data[ACT_BIT]) act_strobe[w_head.ir]   <= 1'b1;
        else                      noact_strobe[w_head.ir] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_debug_cmd_sync.sv
// Directed self-checking bench for cpu_debug_cmd_sync (default parameters;
// timestamp scenario with TS_W=4 when DBG_CMD_TIMESTAMP_EN is defined).
module tb_cpu_debug_cmd_sync;

  logic        clk, reset_n;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        vs_uir, vs_udr, cmd_ready, overrun_clr;
  logic        cmd_valid, overrun;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data, jdo;
  logic [3:0]  act_strobe, noact_strobe;
  logic [1:0]  level;
`ifdef DBG_CMD_TIMESTAMP_EN
  logic [3:0]  cmd_ts;
`endif

  int errors = 0;
  int checks = 0;

  cpu_debug_cmd_sync #(
`ifdef DBG_CMD_TIMESTAMP_EN
    .TS_W(4)
`endif
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .jdo(jdo), .act_strobe(act_strobe),
    .noact_strobe(noact_strobe), .overrun(overrun), .overrun_clr(overrun_clr),
    .level(level)
`ifdef DBG_CMD_TIMESTAMP_EN
    , .cmd_ts(cmd_ts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rising edge on vs_udr; the push lands on the third edge, then the chain drains low.
  task automatic udr_pulse(input logic [37:0] val);
    sr = val; vs_udr = 1'b1;
    step(2);
    vs_udr = 1'b0;
    step(4);
  endtask

  task automatic uir_pulse(input logic [1:0] ir);
    ir_in = ir; vs_uir = 1'b1;
    step(2);
    vs_uir = 1'b0;
    step(4);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; vs_udr = 1'b1; vs_uir = 1'b0; ir_in = 2'd0;
    sr = 38'h1_2345_6789; cmd_ready = 1'b0; overrun_clr = 1'b0;
    #2;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cmd_valid); end
    checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (jdo !== 38'h0) begin errors++; $display("FAIL reset_jdo: got %h expected 0", jdo); end
    checks++; if ({overrun, act_strobe, noact_strobe} !== 9'h0) begin errors++; $display("FAIL reset_flags: got %h expected 0", {overrun, act_strobe, noact_strobe}); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(2);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", cmd_valid); end
    step(1);
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b expected 1", cmd_valid); end
    checks++; if (jdo !== 38'h1_2345_6789) begin errors++; $display("FAIL latency_jdo: got %h expected 1_23456789", jdo); end
    checks++; if (cmd_data !== 38'h1_2345_6789 || cmd_ir !== 2'd0) begin errors++; $display("FAIL latency_head: got ir=%0d data=%h expected ir=0 data=1_23456789", cmd_ir, cmd_data); end
    step(4);
    checks++; if (level !== 2'd1) begin errors++; $display("FAIL held_level_one_event: got %0d expected 1", level); end
    vs_udr = 1'b0;
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    checks++; if (noact_strobe !== 4'b0001 || act_strobe !== 4'b0000) begin errors++; $display("FAIL reset_pop_strobe: got act=%b noact=%b expected act=0000 noact=0001", act_strobe, noact_strobe); end
    step(4);
  endtask

  task automatic test_action;
    uir_pulse(2'd1);
    ir_in = 2'd3;
    udr_pulse(38'h4_0000_0055);
    checks++; if (cmd_ir !== 2'd1 || cmd_data !== 38'h4_0000_0055) begin errors++; $display("FAIL action_head: got ir=%0d data=%h expected ir=1 data=4_00000055", cmd_ir, cmd_data); end
    step(1);
    checks++; if (cmd_data !== 38'h4_0000_0055 || level !== 2'd1) begin errors++; $display("FAIL action_hold: got data=%h level=%0d expected 4_00000055 level=1", cmd_data, level); end
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    checks++; if (act_strobe !== 4'b0010 || noact_strobe !== 4'b0000) begin errors++; $display("FAIL action_strobe: got act=%b noact=%b expected act=0010 noact=0000", act_strobe, noact_strobe); end
    step(1);
    checks++; if (act_strobe !== 4'b0000 || level !== 2'd0) begin errors++; $display("FAIL action_one_cycle: got act=%b level=%0d expected 0000 level=0", act_strobe, level); end
  endtask

  task automatic test_empty;
    cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if ({act_strobe, noact_strobe} !== 8'h0 || level !== 2'd0) begin errors++; $display("FAIL empty_ready_c%0d: got strobes=%h level=%0d expected 00 level=0", i, {act_strobe, noact_strobe}, level); end
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_overrun;
    udr_pulse(38'h0_0000_00A1);
    udr_pulse(38'h0_0000_00A2);
    udr_pulse(38'h0_0000_00A3);
    checks++; if (level !== 2'd2 || overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got level=%0d overrun=%b expected level=2 overrun=1", level, overrun); end
    checks++; if (cmd_data !== 38'h0_0000_00A1) begin errors++; $display("FAIL overrun_first: got %h expected a1", cmd_data); end
    cmd_ready = 1'b1;
    step(1);
    checks++; if (cmd_data !== 38'h0_0000_00A2 || level !== 2'd1) begin errors++; $display("FAIL overrun_second: got data=%h level=%0d expected a2 level=1", cmd_data, level); end
    step(1);
    cmd_ready = 1'b0;
    checks++; if (cmd_valid !== 1'b0 || overrun !== 1'b1) begin errors++; $display("FAIL overrun_drained: got valid=%b overrun=%b expected valid=0 overrun=1", cmd_valid, overrun); end
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr: got %b expected 0", overrun); end
    udr_pulse(38'h0_0000_00B1);
    udr_pulse(38'h0_0000_00B2);
    sr = 38'h0_0000_00B3; vs_udr = 1'b1;
    step(2);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    checks++; if (overrun !== 1'b1 || level !== 2'd2) begin errors++; $display("FAIL overrun_set_wins: got overrun=%b level=%0d expected 1 level=2", overrun, level); end
    vs_udr = 1'b0;
    step(4);
    overrun_clr = 1'b1;
    step(1);
    overrun_clr = 1'b0;
    cmd_ready = 1'b1;
    step(2);
    cmd_ready = 1'b0;
    checks++; if (level !== 2'd0 || overrun !== 1'b0) begin errors++; $display("FAIL overrun_cleanup: got level=%0d overrun=%b expected 0 0", level, overrun); end
    step(2);
  endtask

  task automatic test_back_to_back;
    udr_pulse(38'h0_0000_00D1);
    udr_pulse(38'h0_0000_00D2);
    sr = 38'h0_0000_00D3; vs_udr = 1'b1;
    step(2);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    checks++; if (level !== 2'd2 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_level: got level=%0d overrun=%b expected level=2 overrun=0", level, overrun); end
    checks++; if (cmd_data !== 38'h0_0000_00D2) begin errors++; $display("FAIL b2b_head: got %h expected d2", cmd_data); end
    vs_udr = 1'b0;
    step(4);
    cmd_ready = 1'b1;
    step(1);
    checks++; if (cmd_data !== 38'h0_0000_00D3 || level !== 2'd1) begin errors++; $display("FAIL b2b_last: got data=%h level=%0d expected d3 level=1", cmd_data, level); end
    step(1);
    cmd_ready = 1'b0;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", cmd_valid); end
    step(2);
  endtask

  task automatic test_reset_mid;
    udr_pulse(38'h0_0000_00E1);
    udr_pulse(38'h4_0000_00E2);
    sr = 38'h0_0000_00E3; vs_udr = 1'b1;
    step(1);
    reset_n = 1'b0;
    #1;
    checks++; if (cmd_valid !== 1'b0 || level !== 2'd0) begin errors++; $display("FAIL midreset_fifo: got valid=%b level=%0d expected 0 0", cmd_valid, level); end
    checks++; if (jdo !== 38'h0 || overrun !== 1'b0) begin errors++; $display("FAIL midreset_regs: got jdo=%h overrun=%b expected 0 0", jdo, overrun); end
    vs_udr = 1'b0;
    step(2);
    cmd_ready = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      checks++; if ({act_strobe, noact_strobe} !== 8'h0 || cmd_valid !== 1'b0) begin errors++; $display("FAIL midreset_quiet_c%0d: got strobes=%h valid=%b expected 00 0", i, {act_strobe, noact_strobe}, cmd_valid); end
    end
    cmd_ready = 1'b0;
  endtask

`ifdef DBG_CMD_TIMESTAMP_EN
  task automatic test_timestamp;
    logic [3:0] ts0;
    logic [3:0] diff;
    sr = 38'h0_0000_00F1; vs_udr = 1'b1;
    step(2);
    vs_udr = 1'b0;
    step(18);
    sr = 38'h0_0000_00F2; vs_udr = 1'b1;
    step(2);
    vs_udr = 1'b0;
    step(4);
    checks++; if (level !== 2'd2) begin errors++; $display("FAIL ts_level: got %0d expected 2", level); end
    ts0 = cmd_ts;
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    diff = cmd_ts - ts0;
    checks++; if (diff !== 4'd4) begin errors++; $display("FAIL ts_delta: got %0d expected 4", diff); end
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_action();
    test_empty();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
`ifdef DBG_CMD_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_debug_cmd_sync.md
Name: cpu_debug_cmd_sync

Overview:
- Sysclk-domain command front end for the JTAG debug slave; parametrised successor to the fixed 2-bit-IR / 38-bit action decoder.
- Synchronises the virtual-JTAG update strobes, then latches the IR and snapshots the TCK-domain shift register.
- Queues each update as a command in a small FIFO and presents it to the CPU debug logic with a valid/ready handshake.
- Adds an overrun flag and a one-hot per-instruction action strobe.

Parameters:
- SR_W, 38: shift-register / command data width.
- IR_W, 2: virtual IR width; instruction codes 0..2**IR_W-1.
- SYNC_STAGES, 2: synchroniser depth for vs_uir and vs_udr; legal range 2..4.
- QDEPTH, 2: command FIFO depth; power of two, at least 1.
- ACT_BIT, 34: index into data marking "take action" (1) vs "no action" (0).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ir_in  in  IR_W  virtual IR, TCK domain; stable around vs_uir.
- sr  in  SR_W  JTAG shift register, TCK domain; stable while vs_udr is high.
- vs_uir  in  1  update-IR level, asynchronous.
- vs_udr  in  1  update-DR level, asynchronous.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_ready  in  1  consumer accepts the head.
- cmd_ir  out  IR_W  IR of the head command.
- cmd_data  out  SR_W  data of the head command.
- jdo  out  SR_W  last captured sr; legacy view.
- act_strobe  out  2**IR_W  one-hot pulse on pop, bit = cmd_ir, gated by cmd_data[ACT_BIT].
- noact_strobe  out  2**IR_W  as act_strobe, but only when cmd_data[ACT_BIT]=0.
- overrun  out  1  sticky flag: a command was dropped because the FIFO was full.
- overrun_clr  in  1  synchronous clear of overrun.
- level  out  clog2(QDEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: async assert clears the sync chains, the IR register, jdo, FIFO pointers, level, overrun and all strobes to 0. cmd_valid=0.
- Reset mid-operation discards all queued commands; no strobes fire. Deassertion is used as-is; the integration adds the reset synchroniser.
- Synchronisers: each strobe passes through SYNC_STAGES flops plus one history flop. A rising edge (last stage 1, history 0) yields a one-cycle internal event. Holding a level high produces exactly one event.
- uir event: ir_reg <= ir_in.
- udr event:
  - jdo <= sr.
  - Push {ir_eff, sr}. ir_eff is ir_in if a uir event occurs in the same cycle, otherwise ir_reg.
- Latency: cmd_valid rises SYNC_STAGES+1 clk edges after the first edge that samples vs_udr=1 with an empty FIFO. That is 3 edges at default.
- Pop occurs when cmd_valid && cmd_ready. In the pop cycle the head is visible; strobes are registered and assert on the following cycle for exactly one clock.
  - act_strobe[cmd_ir] when cmd_data[ACT_BIT]=1.
  - noact_strobe[cmd_ir] otherwise.
  - All other strobe bits stay 0.
- FIFO behaviour by case:
  - Empty: cmd_ready is ignored; no strobe fires.
  - Full, push, no pop: command dropped, overrun <= 1, contents unchanged.
  - Full, push and pop in the same cycle: push accepted, level unchanged, overrun unaffected.
  - Empty, push: level 0->1; the head appears next cycle, with no bypass.
  - Pointers wrap modulo QDEPTH; level saturates at QDEPTH.
- overrun_clr with a simultaneous new drop: overrun stays 1 (set wins).
- cmd_ir and cmd_data are held stable while cmd_valid=1 && !cmd_ready.

Optional Feature:
- Macro: DBG_CMD_TIMESTAMP_EN.
- Defined:
  - Adds parameter TS_W (default 16), a free-running TS_W counter reset to 0 and wrapping at 2**TS_W-1, and output cmd_ts [TS_W-1:0].
  - The counter value at the push cycle is stored with each command.
  - cmd_ts follows the head entry with the same stability rules as cmd_data.
- Undefined: no counter, no cmd_ts port, and FIFO width is IR_W+SR_W.

Test Plan:
- Reset with vs_udr=1 held, then release -> one event. After SYNC_STAGES+1 edges: cmd_valid=1 and jdo equals sr.
- vs_uir with ir_in=2'd1, then vs_udr with sr[34]=1 (sr=38'h4_0000_0055), cmd_ready=1 -> cmd_ir=1, cmd_data=38'h4_0000_0055. act_strobe=4'b0010 for exactly one cycle; noact_strobe=0.
- cmd_ready=0, three udr events, QDEPTH=2 -> level=2, overrun=1. Popping yields only the first two sr values in order. overrun_clr clears the flag.
- FIFO full, udr event in the same cycle as a pop -> level stays 2, overrun stays 0, new command is last out.
- Assert reset_n=0 with level=2 and a sync in flight -> all outputs 0 immediately. No strobes after release.
- With DBG_CMD_TIMESTAMP_EN and TS_W=4, 20 cycles between pushes -> cmd_ts values differ by 4 (20 mod 16).
